sequenciador_servo: RTL

Sequencer that drives the 2-bit pulse-width code consumed by the team's PWM generator.
- On command it steps the code through a ping-pong sweep 00→01→10→11→10→01→00.
- Holds each position for a programmable dwell time.
- Repeats the sweep a programmable number of times, then signals completion.
- Sits between the control FSM/pushbuttons and the PWM output stage of the servo/LED experiments.

---
 rtl/sequenciador_servo_pkg.sv | 20 ++
 rtl/sequenciador_servo_if.sv | 26 ++
 rtl/sequenciador_servo_contador_dwell.sv | 27 ++
 rtl/sequenciador_servo.sv | 113 +++++++++++
 4 files changed

// File: rtl/sequenciador_servo_pkg.sv
// Shared types and constants for the servo width-code sequencer.
// State encodings are fixed so db_estado can drive debug displays.
package sequenciador_servo_pkg;

  typedef enum logic [2:0] {
    INICIAL = 3'd0,
    PREPARA = 3'd1,
    ESPERA  = 3'd2,
    PAUSA   = 3'd3,
    FIM     = 3'd4
  } estado_t;

  localparam logic [1:0] L00 = 2'b00;
  localparam logic [1:0] L01 = 2'b01;
  localparam logic [1:0] L10 = 2'b10;
  localparam logic [1:0] L11 = 2'b11;

  localparam int DWELL_50MHZ = 50_000_000;

endpackage

// File: rtl/sequenciador_servo_if.sv
// Command and status bundle between the control side and the sequencer.
// master issues commands; slave is the sequencer itself.
interface sequenciador_servo_if;

  logic       iniciar;
  logic       pausar;
  logic       parar;
  logic [1:0] largura;
  logic       ativo;
  logic       pronto;
  logic [7:0] varreduras;
  logic [2:0] db_estado;

  modport master (
    output iniciar, pausar, parar,
    input  largura, ativo, pronto,
    input  varreduras, db_estado
  );

  modport slave (
    input  iniciar, pausar, parar,
    output largura, ativo, pronto,
    output varreduras, db_estado
  );

endinterface

// File: rtl/sequenciador_servo_contador_dwell.sv
// Modulo-M dwell counter; tc flags the last cycle of each dwell.
// clear wins over enable; a disabled counter holds its value.
module contador_dwell #(
  parameter int M = 4,
  parameter int W = $clog2(M)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         tc
);

  assign tc = enable && (count == W'(M - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/sequenciador_servo.sv
// Ping-pong width-code sequencer 00-01-10-11-10-01-00 for the PWM stage.
// Every output comes straight from a register.
module sequenciador_servo
  import sequenciador_servo_pkg::*;
#(
  parameter int DWELL_CICLOS = DWELL_50MHZ,
  parameter int N_VARREDURAS = 2
) (
  input logic                 clock,
  input logic                 reset,
  sequenciador_servo_if.slave bus
);

  localparam int TW = $clog2(DWELL_CICLOS);

  estado_t       estado, proximo;
  logic [TW-1:0] timer;
  logic          passo;
  logic          limpa, conta;
  logic          desce, desce_n;
  logic [1:0]    largura, larg_n;
  logic [7:0]    varreduras, varr_n;
  logic          fim_ultima;
  logic          ativo, pronto;

  assign limpa = (estado == PREPARA);
  assign conta = (estado == ESPERA);

  contador_dwell #(
    .M (DWELL_CICLOS),
    .W (TW)
  ) u_dwell (
    .clock  (clock),
    .reset  (reset),
    .clear  (limpa),
    .enable (conta),
    .count  (timer),
    .tc     (passo)
  );

  always_comb begin
    assert (timer <= TW'(DWELL_CICLOS - 1));
  end

  // Position update; a sweep closes on the 01->00 step going down.
  always_comb begin
    larg_n     = largura;
    desce_n    = desce;
    varr_n     = varreduras;
    fim_ultima = 1'b0;
    if (estado == PREPARA) begin
      larg_n  = L00;
      desce_n = 1'b0;
      varr_n  = '0;
    end else if (passo) begin
      if (!desce) begin
        larg_n = largura + 2'd1;
        if (largura == L10) desce_n = 1'b1;
      end else begin
        larg_n = largura - 2'd1;
        if (largura == L01) begin
          desce_n = 1'b0;
          if (varreduras != 8'hFF) varr_n = varreduras + 8'd1;
          if (N_VARREDURAS != 0 &&
              32'(varr_n) == N_VARREDURAS)
            fim_ultima = 1'b1;
        end
      end
    end
    if (bus.parar && estado != INICIAL) larg_n = L00;
  end

  always_comb begin
    proximo = estado;
    unique case (estado)
      INICIAL: if (bus.iniciar) proximo = PREPARA;
      PREPARA: proximo = ESPERA;
      ESPERA: begin
        if (fim_ultima)      proximo = FIM;
        else if (bus.pausar) proximo = PAUSA;
      end
      PAUSA:   if (!bus.pausar) proximo = ESPERA;
      FIM:     proximo = INICIAL;
      default: proximo = INICIAL;
    endcase
    if (bus.parar) proximo = INICIAL;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado     <= INICIAL;
      largura    <= L00;
      desce      <= 1'b0;
      varreduras <= '0;
      ativo      <= 1'b0;
      pronto     <= 1'b0;
    end else begin
      estado     <= proximo;
      largura    <= larg_n;
      desce      <= desce_n;
      varreduras <= varr_n;
      ativo      <= (proximo != INICIAL);
      pronto     <= (proximo == FIM);
    end
  end

  assign bus.largura    = largura;
  assign bus.ativo      = ativo;
  assign bus.pronto     = pronto;
  assign bus.varreduras = varreduras;
  assign bus.db_estado  = estado;

endmodule
